// File: rtl/mem_access_router.sv
// Memory access router: arbitrates the functional port and the BIST engine
// over a banked SRAM array, logs BIST-reported faulty words and redirects
// functional accesses to logged addresses into the spare-word bank.

// One fault-table entry: stores a logged word address and compares it
// against the functional request and the incoming fault report.
module mar_cam_entry #(
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              valid,
  input  logic [ADDR_W-1:0] key_a,
  input  logic [ADDR_W-1:0] key_b,
  output logic              hit_a,
  output logic              hit_b
);
  logic [ADDR_W-1:0] entry;

  // capture the faulty address when this slot is the next free one
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)   entry <= '0;
    else if (we) entry <= wr_addr;
  end

  assign hit_a = valid && (entry == key_a);
  assign hit_b = valid && (entry == key_b);
endmodule

module mem_access_router #(
  parameter int DATA_W      = 8,
  parameter int BANK_ADDR_W = 10,
  parameter int BANK_SEL_W  = 6,
  parameter int SPARE_N     = 4,
  parameter int RD_LAT      = 1,
  localparam int NBANK      = 2**BANK_SEL_W,
  localparam int SPARE_W    = $clog2(SPARE_N),
  localparam int ADDR_W     = BANK_SEL_W + BANK_ADDR_W
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      REQ_CSB,
  input  logic                      REQ_WEB,
  input  logic                      REQ_OEB,
  input  logic [ADDR_W-1:0]         REQ_ADDR,
  input  logic [DATA_W-1:0]         REQ_WDATA,
  input  logic                      BIST_EN,
  input  logic [NBANK-1:0]          BIST_CSB,
  input  logic [NBANK-1:0]          BIST_OEB,
  input  logic                      BIST_WEB,
  input  logic [BANK_ADDR_W-1:0]    BIST_ADDR,
  input  logic [DATA_W-1:0]         BIST_WDATA,
  input  logic                      FAULT_PUSH,
  input  logic [ADDR_W-1:0]         FAULT_ADDR,
  output logic [BANK_ADDR_W-1:0]    MEM_ADDR,
  output logic                      MEM_WEB,
  output logic [DATA_W-1:0]         MEM_WDATA,
  output logic [NBANK-1:0]          MEM_CSB,
  output logic [NBANK-1:0]          MEM_OEB,
  input  logic [NBANK*DATA_W-1:0]   MEM_RDATA,
  output logic [SPARE_W-1:0]        SPARE_ADDR,
  output logic                      SPARE_CSB,
  output logic                      SPARE_WEB,
  output logic                      SPARE_OEB,
  output logic [DATA_W-1:0]         SPARE_WDATA,
  input  logic [DATA_W-1:0]         SPARE_RDATA,
  output logic [DATA_W-1:0]         RDATA,
  output logic                      RDATA_VALID,
  output logic [1:0]                MODE,
  output logic [SPARE_W:0]          FAULT_COUNT,
  output logic                      REPAIR_FAIL
);

  typedef enum logic [1:0] {S_FUNC = 2'b00, S_BIST = 2'b01, S_DRAIN = 2'b10} state_t;

  typedef struct packed {
    logic                  spare;
    logic [BANK_SEL_W-1:0] bank;
  } tag_t;

  state_t state, state_n;
  logic   clr_tbl, issue_func, issue_bist;

  logic [RD_LAT:0] vld_pipe;
  tag_t            tag_pipe [RD_LAT+1];
  tag_t            push_tag;
  logic            push_vld;

  logic [SPARE_N-1:0]    func_hit, fault_hit;
  logic [SPARE_W-1:0]    hit_idx;
  logic                  any_hit, tbl_full, log_ok, log_we;
  logic [BANK_SEL_W-1:0] bank_sel, bist_bank;
  logic [NBANK-1:0]      bank_oh;
  logic                  func_rd, bist_rd;

  assign bank_sel = REQ_ADDR[ADDR_W-1:BANK_ADDR_W];
  assign bank_oh  = NBANK'(1) << bank_sel;
  assign any_hit  = |func_hit;
  assign tbl_full = (FAULT_COUNT == (SPARE_W+1)'(SPARE_N));
  assign log_ok   = (state == S_BIST) && FAULT_PUSH && !(|fault_hit);
  assign log_we   = log_ok && !tbl_full;
  assign func_rd  = !REQ_CSB && REQ_WEB && !REQ_OEB;
  assign bist_rd  = BIST_WEB && (|(~BIST_CSB & ~BIST_OEB));
  assign MODE     = state;

  for (genvar i = 0; i < SPARE_N; i++) begin : g_ent
    mar_cam_entry #(.ADDR_W(ADDR_W)) u_ent (
      .CLK     (CLK),
      .RSTN    (RSTN),
      .we      (log_we && (FAULT_COUNT == (SPARE_W+1)'(i))),
      .wr_addr (FAULT_ADDR),
      .valid   (FAULT_COUNT > (SPARE_W+1)'(i)),
      .key_a   (REQ_ADDR),
      .key_b   (FAULT_ADDR),
      .hit_a   (func_hit[i]),
      .hit_b   (fault_hit[i])
    );
  end

  // logged addresses are unique, so at most one entry hits; lowest index kept anyway
  always_comb begin
    hit_idx = '0;
    for (int i = SPARE_N-1; i >= 0; i--)
      if (func_hit[i]) hit_idx = SPARE_W'(i);
  end

  // BIST read tag: lowest bank with both CSB and OEB asserted
  always_comb begin
    bist_bank = '0;
    for (int b = NBANK-1; b >= 0; b--)
      if (!BIST_CSB[b] && !BIST_OEB[b]) bist_bank = BANK_SEL_W'(b);
  end

  // mode sequencing; a mode change always passes through DRAIN and drops that cycle's request
  always_comb begin
    state_n    = state;
    clr_tbl    = 1'b0;
    issue_func = 1'b0;
    issue_bist = 1'b0;
    case (state)
      S_FUNC: begin
        if (BIST_EN) begin
          state_n = S_DRAIN;
          clr_tbl = 1'b1;
        end else begin
          issue_func = !REQ_CSB;
        end
      end
      S_BIST: begin
        if (!BIST_EN) state_n = S_DRAIN;
        else          issue_bist = 1'b1;
      end
      S_DRAIN: begin
        // target follows the live BIST_EN level so toggling retargets the drain
        if (!(|vld_pipe)) state_n = BIST_EN ? S_BIST : S_FUNC;
      end
      default: state_n = S_FUNC;
    endcase
  end

  // read tag for whatever is issued this cycle
  always_comb begin
    push_vld       = (issue_func && func_rd) || (issue_bist && bist_rd);
    push_tag.spare = issue_func && any_hit;
    push_tag.bank  = issue_func ? bank_sel : bist_bank;
  end

  // mode register and registered macro / spare controls
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= S_FUNC;
      MEM_ADDR    <= '0;
      MEM_WEB     <= 1'b1;
      MEM_WDATA   <= '0;
      MEM_CSB     <= '1;
      MEM_OEB     <= '1;
      SPARE_ADDR  <= '0;
      SPARE_CSB   <= 1'b1;
      SPARE_WEB   <= 1'b1;
      SPARE_OEB   <= 1'b1;
      SPARE_WDATA <= '0;
    end else begin
      state     <= state_n;
      MEM_CSB   <= '1;
      MEM_OEB   <= '1;
      MEM_WEB   <= 1'b1;
      SPARE_CSB <= 1'b1;
      SPARE_WEB <= 1'b1;
      SPARE_OEB <= 1'b1;
      if (issue_func) begin
        if (any_hit) begin
          SPARE_ADDR  <= hit_idx;
          SPARE_CSB   <= 1'b0;
          SPARE_WEB   <= REQ_WEB;
          SPARE_OEB   <= REQ_OEB;
          SPARE_WDATA <= REQ_WDATA;
        end else begin
          MEM_ADDR  <= REQ_ADDR[BANK_ADDR_W-1:0];
          MEM_CSB   <= ~bank_oh;
          MEM_OEB   <= ~bank_oh | {NBANK{REQ_OEB}};
          MEM_WEB   <= REQ_WEB;
          MEM_WDATA <= REQ_WDATA;
        end
      end else if (issue_bist) begin
        MEM_ADDR  <= BIST_ADDR;
        MEM_CSB   <= BIST_CSB;
        MEM_OEB   <= BIST_OEB;
        MEM_WEB   <= BIST_WEB;
        MEM_WDATA <= BIST_WDATA;
      end
    end
  end

  // read-tracking shift register; stage RD_LAT lines up with macro data
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_pipe <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[RD_LAT-1:0], push_vld};
      tag_pipe[0] <= push_tag;
      for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // single registered return path; RDATA holds between strobes
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      RDATA       <= '0;
      RDATA_VALID <= 1'b0;
    end else begin
      RDATA_VALID <= vld_pipe[RD_LAT];
      if (vld_pipe[RD_LAT])
        RDATA <= tag_pipe[RD_LAT].spare ? SPARE_RDATA
                                        : MEM_RDATA[tag_pipe[RD_LAT].bank*DATA_W +: DATA_W];
    end
  end

  // fault table occupancy and sticky overflow, cleared on each BIST entry
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      FAULT_COUNT <= '0;
      REPAIR_FAIL <= 1'b0;
    end else if (clr_tbl) begin
      FAULT_COUNT <= '0;
      REPAIR_FAIL <= 1'b0;
    end else if (log_ok) begin
      if (!tbl_full) FAULT_COUNT <= FAULT_COUNT + 1'b1;
      else           REPAIR_FAIL <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_router.sv
// Directed bench: default router (RD_LAT=1, 64 banks) plus a
// RD_LAT=3 / 4-bank instance for streaming and async reset.
module tb_mem_access_router;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // ---------------- instance 0: defaults ----------------
  logic         rstn0;
  logic         r0_csb, r0_web, r0_oeb;
  logic [15:0]  r0_addr;
  logic [7:0]   r0_wd;
  logic         ben0, bweb0, fpush0;
  logic [63:0]  bcsb0, boeb0;
  logic [9:0]   baddr0;
  logic [7:0]   bwd0;
  logic [15:0]  faddr0;
  logic [9:0]   ma0;
  logic         mweb0;
  logic [7:0]   mwd0;
  logic [63:0]  mcsb0, moeb0;
  logic [511:0] mrd0;
  logic [1:0]   sa0;
  logic         scsb0, sweb0, soeb0;
  logic [7:0]   swd0, srd0, rd0;
  logic         rv0, rf0;
  logic [1:0]   mode0;
  logic [2:0]   fc0;

  mem_access_router u_dut0 (
    .CLK(CLK), .RSTN(rstn0),
    .REQ_CSB(r0_csb), .REQ_WEB(r0_web), .REQ_OEB(r0_oeb), .REQ_ADDR(r0_addr), .REQ_WDATA(r0_wd),
    .BIST_EN(ben0), .BIST_CSB(bcsb0), .BIST_OEB(boeb0), .BIST_WEB(bweb0), .BIST_ADDR(baddr0),
    .BIST_WDATA(bwd0), .FAULT_PUSH(fpush0), .FAULT_ADDR(faddr0),
    .MEM_ADDR(ma0), .MEM_WEB(mweb0), .MEM_WDATA(mwd0), .MEM_CSB(mcsb0), .MEM_OEB(moeb0),
    .MEM_RDATA(mrd0), .SPARE_ADDR(sa0), .SPARE_CSB(scsb0), .SPARE_WEB(sweb0), .SPARE_OEB(soeb0),
    .SPARE_WDATA(swd0), .SPARE_RDATA(srd0), .RDATA(rd0), .RDATA_VALID(rv0), .MODE(mode0),
    .FAULT_COUNT(fc0), .REPAIR_FAIL(rf0)
  );

  // SRAM array and spare bank models, 1-clock read latency
  logic [7:0] mem0 [0:65535];
  logic [7:0] sp0  [0:3];
  always @(posedge CLK) begin
    for (int b = 0; b < 64; b++)
      if (!mcsb0[b]) begin
        if (!mweb0)         mem0[{b[5:0], ma0}] <= mwd0;
        else if (!moeb0[b]) mrd0[b*8 +: 8]      <= mem0[{b[5:0], ma0}];
      end
    if (!scsb0) begin
      if (!sweb0)      sp0[sa0] <= swd0;
      else if (!soeb0) srd0     <= sp0[sa0];
    end
  end

  // ---------------- instance 1: RD_LAT=3, 4 banks ----------------
  logic         rstn1;
  logic         r1_csb, r1_web, r1_oeb;
  logic [11:0]  r1_addr;
  logic [7:0]   r1_wd;
  logic         ben1, bweb1, fpush1;
  logic [3:0]   bcsb1, boeb1;
  logic [9:0]   baddr1;
  logic [7:0]   bwd1;
  logic [11:0]  faddr1;
  logic [9:0]   ma1;
  logic         mweb1;
  logic [7:0]   mwd1;
  logic [3:0]   mcsb1, moeb1;
  logic [31:0]  mrd1;
  logic [1:0]   sa1;
  logic         scsb1, sweb1, soeb1;
  logic [7:0]   swd1, rd1;
  logic [7:0]   srd1;
  logic         rv1, rf1;
  logic [1:0]   mode1;
  logic [2:0]   fc1;

  mem_access_router #(.BANK_SEL_W(2), .RD_LAT(3)) u_dut1 (
    .CLK(CLK), .RSTN(rstn1),
    .REQ_CSB(r1_csb), .REQ_WEB(r1_web), .REQ_OEB(r1_oeb), .REQ_ADDR(r1_addr), .REQ_WDATA(r1_wd),
    .BIST_EN(ben1), .BIST_CSB(bcsb1), .BIST_OEB(boeb1), .BIST_WEB(bweb1), .BIST_ADDR(baddr1),
    .BIST_WDATA(bwd1), .FAULT_PUSH(fpush1), .FAULT_ADDR(faddr1),
    .MEM_ADDR(ma1), .MEM_WEB(mweb1), .MEM_WDATA(mwd1), .MEM_CSB(mcsb1), .MEM_OEB(moeb1),
    .MEM_RDATA(mrd1), .SPARE_ADDR(sa1), .SPARE_CSB(scsb1), .SPARE_WEB(sweb1), .SPARE_OEB(soeb1),
    .SPARE_WDATA(swd1), .SPARE_RDATA(srd1), .RDATA(rd1), .RDATA_VALID(rv1), .MODE(mode1),
    .FAULT_COUNT(fc1), .REPAIR_FAIL(rf1)
  );

  // ROM-like banks: word = {bank, addr[5:0]}, 3-clock read latency
  logic [31:0] m1s [0:2];
  assign mrd1 = m1s[2];
  always @(posedge CLK) begin
    logic [31:0] t;
    t = m1s[0];
    for (int b = 0; b < 4; b++)
      if (!mcsb1[b] && !moeb1[b] && mweb1) t[b*8 +: 8] = {b[1:0], ma1[5:0]};
    m1s[0] <= t;
    m1s[1] <= m1s[0];
    m1s[2] <= m1s[1];
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle0;
    r0_csb = 1'b1; r0_web = 1'b1; r0_oeb = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        spare;
    logic [1:0]  sidx;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vt [9];

  // optional write, then read back through the registered return path
  task automatic apply_vec(input vec_t v);
    logic [63:0] ecs;
    ecs = ~(64'd1 << v.addr[15:10]);
    if (v.wr) begin
      r0_csb = 1'b0; r0_web = 1'b0; r0_oeb = 1'b1; r0_addr = v.addr; r0_wd = v.wd;
      tick;
      if (v.spare) begin
        chk("wr_spare_csb", scsb0, 1'b0);
        chk("wr_spare_addr", sa0, v.sidx);
        chk("wr_spare_web", sweb0, 1'b0);
        chk("wr_spare_wdata", swd0, v.wd);
        chk("wr_spare_mem_csb", mcsb0, '1);
      end else begin
        chk("wr_mem_csb", mcsb0, ecs);
        chk("wr_mem_addr", ma0, v.addr[9:0]);
        chk("wr_mem_web", mweb0, 1'b0);
        chk("wr_mem_wdata", mwd0, v.wd);
        chk("wr_mem_spare_csb", scsb0, 1'b1);
      end
    end
    r0_csb = 1'b0; r0_web = 1'b1; r0_oeb = 1'b0; r0_addr = v.addr;
    tick;
    if (v.spare) begin
      chk("rd_spare_oeb", soeb0, 1'b0);
      chk("rd_spare_addr", sa0, v.sidx);
      chk("rd_spare_mem_oeb", moeb0, '1);
    end else begin
      chk("rd_mem_oeb", moeb0, ecs);
      chk("rd_mem_addr", ma0, v.addr[9:0]);
    end
    idle0;
    tick;
    chk("rd_valid_early", rv0, 1'b0);
    tick;
    chk("rd_valid", rv0, 1'b1);
    chk("rd_data", rd0, v.exp_rd);
    tick;
    chk("rd_valid_drop", rv0, 1'b0);
    chk("rd_data_hold", rd0, v.exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bk;
    vt[0] = '{1'b1, 16'h0C05, 8'hA5, 1'b0, 2'd0, 8'hA5};
    vt[1] = '{1'b1, 16'hFC05, 8'h5C, 1'b0, 2'd0, 8'h5C};
    vt[2] = '{1'b0, 16'h0C05, 8'h00, 1'b0, 2'd0, 8'hA5};
    vt[3] = '{1'b1, 16'h03FF, 8'h11, 1'b0, 2'd0, 8'h11};
    vt[4] = '{1'b0, 16'hFC05, 8'h00, 1'b0, 2'd0, 8'h5C};
    vt[5] = '{1'b1, 16'h2000, 8'h3C, 1'b1, 2'd1, 8'h3C};
    vt[6] = '{1'b1, 16'h0123, 8'h99, 1'b1, 2'd0, 8'h99};
    vt[7] = '{1'b1, 16'h2001, 8'h42, 1'b0, 2'd0, 8'h42};
    vt[8] = '{1'b0, 16'h2000, 8'h00, 1'b1, 2'd1, 8'h3C};

    rstn0 = 1'b0; rstn1 = 1'b0;
    idle0; r0_addr = '0; r0_wd = '0;
    ben0 = 1'b0; bcsb0 = '1; boeb0 = '1; bweb0 = 1'b1; baddr0 = '0; bwd0 = '0;
    fpush0 = 1'b0; faddr0 = '0;
    r1_csb = 1'b1; r1_web = 1'b1; r1_oeb = 1'b1; r1_addr = '0; r1_wd = '0;
    ben1 = 1'b0; bcsb1 = '1; boeb1 = '1; bweb1 = 1'b1; baddr1 = '0; bwd1 = '0;
    fpush1 = 1'b0; faddr1 = '0; srd1 = '0;

    #12;
    chk("rst_mem_csb", mcsb0, '1);
    chk("rst_mem_oeb", moeb0, '1);
    chk("rst_mem_web", mweb0, 1'b1);
    chk("rst_mem_addr", ma0, '0);
    chk("rst_mem_wdata", mwd0, '0);
    chk("rst_spare_ctl", {scsb0, sweb0, soeb0}, 3'b111);
    chk("rst_spare_addr", sa0, '0);
    chk("rst_rdata", rd0, '0);
    chk("rst_rvalid", rv0, 1'b0);
    chk("rst_mode", mode0, 2'b00);
    chk("rst_fcount", fc0, '0);
    chk("rst_rfail", rf0, 1'b0);
    chk("rst1_mem_csb", mcsb1, 4'hF);
    @(negedge CLK);
    rstn0 = 1'b1; rstn1 = 1'b1;
    tick;

    // functional accesses with no faults logged
    for (int i = 0; i < 5; i++) apply_vec(vt[i]);

    // BIST request while a read is in flight: drain until it returns
    r0_csb = 1'b0; r0_web = 1'b1; r0_oeb = 1'b0; r0_addr = 16'h0C05;
    tick;
    idle0; ben0 = 1'b1;
    tick;
    chk("drain_mode", mode0, 2'b10);
    chk("drain_mem_csb", mcsb0, '1);
    chk("drain_mem_oeb", moeb0, '1);
    chk("drain_rvalid_early", rv0, 1'b0);
    tick;
    chk("drain_mode_hold", mode0, 2'b10);
    chk("drain_rvalid", rv0, 1'b1);
    chk("drain_rdata", rd0, 8'hA5);
    tick;
    chk("bist_mode", mode0, 2'b01);

    // BIST pass-through write; functional request must be ignored
    r0_csb = 1'b0; r0_web = 1'b0; r0_addr = 16'h2000;
    bcsb0 = ~(64'd1 << 2); bweb0 = 1'b0; baddr0 = 10'd7; bwd0 = 8'h5A;
    tick;
    chk("bist_wr_csb", mcsb0, ~(64'd1 << 2));
    chk("bist_wr_web", mweb0, 1'b0);
    chk("bist_wr_addr", ma0, 10'd7);
    chk("bist_wr_wdata", mwd0, 8'h5A);
    chk("bist_func_ignored", scsb0, 1'b1);
    idle0;
    // two banks read at once: tag takes the lowest (bank 2)
    bcsb0 = ~((64'd1 << 2) | (64'd1 << 5)); boeb0 = bcsb0; bweb0 = 1'b1;
    tick;
    chk("bist_rd_oeb", moeb0, ~((64'd1 << 2) | (64'd1 << 5)));
    bcsb0 = '1; boeb0 = '1;
    tick;
    tick;
    chk("bist_rd_valid", rv0, 1'b1);
    chk("bist_rd_lowest", rd0, 8'h5A);

    // fault logging with a duplicate
    fpush0 = 1'b1; faddr0 = 16'h0123;
    tick; chk("log_first", fc0, 3'd1);
    tick; chk("log_dup", fc0, 3'd1);
    faddr0 = 16'h2000;
    tick; chk("log_second", fc0, 3'd2);
    fpush0 = 1'b0;

    ben0 = 1'b0;
    tick; chk("exit_drain_mode", mode0, 2'b10);
    tick; chk("exit_func_mode", mode0, 2'b00);
    chk("table_persists", fc0, 3'd2);

    // functional accesses redirected to spares
    for (int i = 5; i < 9; i++) apply_vec(vt[i]);

    // pushes outside BIST are ignored
    fpush0 = 1'b1; faddr0 = 16'h3333;
    tick; chk("push_func_ignored", fc0, 3'd2);
    fpush0 = 1'b0; ben0 = 1'b1;
    tick;
    chk("enter_drain_mode", mode0, 2'b10);
    chk("enter_clears_count", fc0, 3'd0);
    fpush0 = 1'b1; faddr0 = 16'h4444;
    tick;
    chk("drain_to_bist", mode0, 2'b01);
    chk("push_drain_ignored", fc0, 3'd0);

    // overflow: fifth distinct address sets the sticky flag
    for (int i = 0; i < 5; i++) begin
      faddr0 = 16'h1000 + 16'(i);
      tick;
      chk("ovf_count", fc0, (i < 4) ? 3'(i + 1) : 3'd4);
      chk("ovf_fail", rf0, (i == 4));
    end
    fpush0 = 1'b0; ben0 = 1'b0;
    tick; tick;
    chk("ovf_func_mode", mode0, 2'b00);
    chk("ovf_count_persist", fc0, 3'd4);
    chk("ovf_fail_persist", rf0, 1'b1);
    ben0 = 1'b1;
    tick;
    chk("reentry_count_clr", fc0, 3'd0);
    chk("reentry_fail_clr", rf0, 1'b0);
    ben0 = 1'b0;

    // instance 1: back-to-back reads alternating banks 0 and 2
    for (int c = 0; c < 13; c++) begin
      if (c < 8) begin
        bk = c[0] ? 2'd2 : 2'd0;
        r1_csb = 1'b0; r1_web = 1'b1; r1_oeb = 1'b0; r1_addr = {bk, 10'(c + 1)};
      end else begin
        r1_csb = 1'b1; r1_oeb = 1'b1;
      end
      tick;
      if (c >= 4 && c < 12) begin
        bk = c[0] ? 2'd2 : 2'd0;
        chk("stream_valid", rv1, 1'b1);
        chk("stream_data", rd1, {bk, 6'(c - 3)});
      end else begin
        chk("stream_idle", rv1, 1'b0);
      end
    end

    // async reset in the middle of a read stream
    for (int c = 0; c < 3; c++) begin
      r1_csb = 1'b0; r1_web = 1'b1; r1_oeb = 1'b0; r1_addr = {2'd2, 10'(c + 5)};
      tick;
    end
    #2 rstn1 = 1'b0;
    #1;
    chk("arst_mem_csb", mcsb1, 4'hF);
    chk("arst_mem_oeb", moeb1, 4'hF);
    chk("arst_mem_addr", ma1, '0);
    chk("arst_rdata", rd1, '0);
    chk("arst_rvalid", rv1, 1'b0);
    chk("arst_mode", mode1, 2'b00);
    r1_csb = 1'b1; r1_oeb = 1'b1;
    #2 rstn1 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      chk("arst_discard", rv1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_router.md
# mem_access_router

Parametrised memory access router for the banked SRAM array and its spare-word bank. It arbitrates between the functional port and the BIST engine through a mode state machine with a drain phase, logs faulty word addresses reported during BIST into a fault table, and transparently redirects functional accesses to logged addresses into spare entries. Read data from either bank set returns on one registered path with a valid strobe. It sits between the SoC bus-side controller/BIST engine and the SRAM macros.

## Interface
- DATA_W, 8, data width of every macro
- BANK_ADDR_W, 10, word address width inside one bank
- BANK_SEL_W, 6, bank select width; NBANK = 2**BANK_SEL_W
- SPARE_N, 4, fault-table entries = spare words (power of two, >= 2); SPARE_W = log2(SPARE_N)
- RD_LAT, 1, macro read latency in clocks (>= 1)
- ADDR_W = BANK_SEL_W + BANK_ADDR_W (derived)

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- REQ_CSB / REQ_WEB / REQ_OEB  in  1 each  functional strobes, active-low
- REQ_ADDR  in  ADDR_W  functional address; [ADDR_W-1:BANK_ADDR_W] = bank
- REQ_WDATA  in  DATA_W  functional write data
- BIST_EN  in  1  level request for BIST mode
- BIST_CSB / BIST_OEB  in  NBANK each  per-bank BIST strobes
- BIST_WEB  in  1; BIST_ADDR  in  BANK_ADDR_W; BIST_WDATA  in  DATA_W
- FAULT_PUSH  in  1  log FAULT_ADDR this cycle
- FAULT_ADDR  in  ADDR_W  faulty word address
- MEM_ADDR  out  BANK_ADDR_W; MEM_WEB  out  1; MEM_WDATA  out  DATA_W
- MEM_CSB / MEM_OEB  out  NBANK each  one-hot-low bank strobes
- MEM_RDATA  in  NBANK*DATA_W  bank b at [b*DATA_W +: DATA_W]
- SPARE_ADDR  out  SPARE_W; SPARE_CSB / SPARE_WEB / SPARE_OEB  out  1 each; SPARE_WDATA  out  DATA_W
- SPARE_RDATA  in  DATA_W
- RDATA  out  DATA_W; RDATA_VALID  out  1
- MODE  out  2  00 FUNC, 01 BIST, 10 DRAIN
- FAULT_COUNT  out  SPARE_W+1  valid table entries
- REPAIR_FAIL  out  1  sticky table overflow

## Operation
- States: FUNC, DRAIN, BIST. Reset -> FUNC.
- FUNC: BIST_EN=1 -> DRAIN, target BIST; table cleared (count 0, REPAIR_FAIL 0) on this transition.
- BIST: BIST_EN=0 -> DRAIN, target FUNC.
- DRAIN: all CSB/OEB/WEB outputs high; new requests dropped; stays until read-tracking pipeline empty (>= 1 cycle), then target state. BIST_EN toggling in DRAIN retargets it.
- FUNC access: CSB low. Bank b = REQ_ADDR bank field. Compare REQ_ADDR with all valid entries. Hit at entry i: SPARE_ADDR=i, SPARE_CSB=0, SPARE_WEB/OEB=REQ_WEB/OEB, SPARE_WDATA=REQ_WDATA, all MEM_CSB/OEB high. Miss: MEM_ADDR=low field, MEM_CSB=~(1<<b), MEM_OEB=~(1<<b) | {NBANK{REQ_OEB}}, MEM_WEB=REQ_WEB, MEM_WDATA=REQ_WDATA; spare idle.
- BIST: MEM_* driven straight from BIST_* inputs; spare idle; functional port ignored.
- Read = selected CSB low, WEB high, OEB low. Each issued read pushes tag {valid, spare, bank} into an RD_LAT-deep pipeline; at exit RDATA takes SPARE_RDATA or the tagged bank slice. BIST reads tag bank = lowest index with CSB and OEB both low; several simultaneous -> lowest wins.
- Fault logging only in BIST state; pushes elsewhere ignored. Address already in table: ignored. Table not full: write at index FAULT_COUNT, count+1. Full, new address: dropped, REPAIR_FAIL=1 until next FUNC->DRAIN.
- Table persists through FUNC until next BIST entry.

## Timing
- All outputs registered. Request sampled at edge k -> macro/spare controls valid after edge k.
- Read sampled at k -> RDATA/RDATA_VALID after edge k+RD_LAT+1, valid one cycle; RDATA holds otherwise.
- Fault push at k -> visible in table/FAULT_COUNT after k; FUNC access at k+1 can already hit.
- Back-to-back reads every cycle sustained; pipeline never stalls.
- Reset: MEM_CSB/MEM_OEB all ones, MEM_WEB 1, MEM_ADDR/MEM_WDATA 0; SPARE_CSB/WEB/OEB 1, SPARE_ADDR/WDATA 0; RDATA 0, RDATA_VALID 0; MODE 00; FAULT_COUNT 0; REPAIR_FAIL 0; pipeline empty. Reset mid-read discards it.

## Test plan
- Defaults, RD_LAT=1: write 0xA5 to 0x0C05, read it -> MEM_CSB bit 3 low only, MEM_ADDR=0x005; RDATA=0xA5, RDATA_VALID two edges after read sample.
- Mode switch: raise BIST_EN with read in flight -> MODE 10 until that RDATA_VALID, then 01; outputs idle during 10; drop BIST_EN -> 10 then 00.
- Fault log: in BIST push 0x0123, 0x0123, 0x2000 -> FAULT_COUNT 2; in FUNC write/read 0x2000 with 0x3C -> SPARE_ADDR=1, MEM_CSB all ones, RDATA=0x3C from SPARE_RDATA.
- Overflow: push 5 distinct addresses (SPARE_N=4) -> FAULT_COUNT 4, REPAIR_FAIL 1; re-enter BIST -> both cleared.
- Pushes while MODE=00 or 10 -> FAULT_COUNT unchanged.
- RD_LAT=3, NBANK=4: reads every cycle alternating banks 0/2 -> RDATA_VALID continuous, data matches bank order; async reset mid-stream -> all outputs to reset values immediately.
